// File: rtl/amns_pkg.sv
// ============================================================================
//  Module      : amns_pkg
//  Description : Shared types and layout helpers for the AMNS host loader.
//                Holds the loader state encoding and the BRAM operand layout
//                (M'_0, M, A, B regions) as functions of N and s.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package amns_pkg;

  // Loader control states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    FLUSH     = 3'd2,
    START     = 3'd3,
    WAIT_CORE = 3'd4,
    UNLOAD    = 3'd5
  } state_t;

  // Region base offsets inside the shared operand/result BRAM
  function automatic int amns_base_m0(input int n, input int s);
    return 0;
  endfunction

  function automatic int amns_base_m(input int n, input int s);
    return n;
  endfunction

  function automatic int amns_base_a(input int n, input int s);
    return n + n * s;
  endfunction

  function automatic int amns_base_b(input int n, input int s);
    return n + 2 * n * s;
  endfunction

  // Result words produced by the core (read back from address 0 upward)
  function automatic int amns_res_words(input int n, input int s);
    return n * s;
  endfunction

  // Operand words: the load ends where the B region ends
  function automatic int amns_load_words(input int n, input int s);
    return amns_base_b(n, s) + amns_res_words(n, s);
  endfunction

  // BRAM address width covering the whole 4*N*s word window
  function automatic int amns_addr_w(input int n, input int s);
    return $clog2(4 * n * s);
  endfunction

endpackage

`default_nettype wire

// File: rtl/amns_readback_fifo.sv
// ============================================================================
//  Module      : amns_readback_fifo
//  Description : Small synchronous FIFO catching BRAM read data during result
//                readback. Exposes its occupancy so the loader can issue reads
//                on credit and never overrun it. Head word drives the output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module amns_readback_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   occ
);

  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [OCC_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO or a pop from an empty one is ignored
  assign do_push = push && (cnt != OCC_W'(DEPTH));
  assign do_pop  = pop && (cnt != '0);

  assign dout  = mem[rp];
  assign valid = (cnt != '0);
  assign occ   = cnt;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= (wp == PW'(DEPTH - 1)) ? '0 : wp + PW'(1);
      end
      if (do_pop) begin
        rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + OCC_W'(1);
        2'b01:   cnt <= cnt - OCC_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/amns_host_loader.sv
// ============================================================================
//  Module      : amns_host_loader
//  Description : Host front end of the AMNS multiplier. Streams one operand
//                set into the shared BRAM (M'_0, M, A, B), pulses the core
//                start, waits for done, then streams the N*s result words out
//                with valid/ready/last.
//                Optional: define AMNS_LOADER_TIMEOUT_EN to add a watchdog on
//                the core done that flags error_o after TIMEOUT_CYCLES.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module amns_host_loader
  import amns_pkg::*;
#(
  parameter int S              = 5,
  parameter int N              = 5,
  parameter int WORD_W         = 64,
  parameter int RD_LAT         = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                        clock_i,
  input  logic                        reset_n_i,
  input  logic [WORD_W-1:0]           s_tdata_i,
  input  logic                        s_tvalid_i,
  output logic                        s_tready_o,
  input  logic                        s_tlast_i,
  output logic [WORD_W-1:0]           m_tdata_o,
  output logic                        m_tvalid_o,
  input  logic                        m_tready_i,
  output logic                        m_tlast_o,
  output logic [amns_addr_w(N,S)-1:0] bram_addr_o,
  output logic                        bram_en_o,
  output logic                        bram_we_o,
  output logic [WORD_W-1:0]           bram_wdata_o,
  input  logic [WORD_W-1:0]           bram_rdata_i,
  output logic                        core_rst_o,
  output logic                        core_start_o,
  input  logic                        core_done_i,
  output logic                        busy_o,
  output logic                        error_o
);

  localparam int AW         = amns_addr_w(N, S);
  localparam int LOAD_WORDS = amns_load_words(N, S);
  localparam int RES_WORDS  = amns_res_words(N, S);
  localparam int DEPTH      = RD_LAT + 2;
  localparam int OCC_W      = $clog2(DEPTH + 1);
  localparam int SUM_W      = OCC_W + 1;

  localparam logic [AW-1:0] LAST_LOAD = AW'(LOAD_WORDS - 1);
  localparam logic [AW-1:0] RES_END   = AW'(RES_WORDS);
  localparam logic [AW-1:0] RES_LAST  = AW'(RES_WORDS - 1);

  if (RD_LAT < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("amns_host_loader: RD_LAT and TIMEOUT_CYCLES must be at least 1");
  end

  state_t            state;
  logic [AW-1:0]     cnt;
  logic [AW-1:0]     rd_addr;
  logic [AW-1:0]     out_cnt;
  logic              ready_q;
  logic              core_rst_q;
  logic              start_q;
  logic              busy_q;
  logic              err_q;
  logic [RD_LAT-1:0] pipe;
  logic [OCC_W-1:0]  inflight;
  logic [OCC_W-1:0]  occ;
  logic [SUM_W-1:0]  credit;
  logic              accept;
  logic              load_wr;
  logic              issue;
  logic              fifo_valid;
  logic              pop;

`ifdef AMNS_LOADER_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [31:0] tcnt;
`endif

  assign accept  = s_tvalid_i & ready_q;
  assign load_wr = accept & ((state == IDLE) | (state == LOAD));

  // Reads already issued but not yet landed in the FIFO
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + OCC_W'(pipe[i]);
    end
  end

  // A read only goes out when its data is guaranteed a FIFO slot
  assign credit = {1'b0, occ} + {1'b0, inflight};
  assign issue  = (state == UNLOAD) && (rd_addr < RES_END) && (credit < SUM_W'(DEPTH));
  assign pop    = fifo_valid & m_tready_i;

  assign bram_en_o    = load_wr | issue;
  assign bram_we_o    = load_wr;
  assign bram_addr_o  = (state == UNLOAD) ? rd_addr : cnt;
  assign bram_wdata_o = load_wr ? s_tdata_i : '0;

  assign s_tready_o   = ready_q;
  assign core_rst_o   = core_rst_q;
  assign core_start_o = start_q;
  assign busy_o       = busy_q;
  assign error_o      = err_q;
  assign m_tvalid_o   = fifo_valid;
  assign m_tlast_o    = fifo_valid & (out_cnt == RES_LAST);

  // Read-latency tracker: a bit per issued read, marching toward the FIFO
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pipe <= '0;
    end else begin
      pipe <= (pipe << 1) | RD_LAT'(issue);
    end
  end

  amns_readback_fifo #(
    .DEPTH (DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk   (clock_i),
    .rst_n (reset_n_i),
    .push  (pipe[RD_LAT-1]),
    .din   (bram_rdata_i),
    .pop   (pop),
    .dout  (m_tdata_o),
    .valid (fifo_valid),
    .occ   (occ)
  );

  // Control FSM with registered handshake/core outputs
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state      <= IDLE;
      cnt        <= '0;
      rd_addr    <= '0;
      out_cnt    <= '0;
      ready_q    <= 1'b0;
      core_rst_q <= 1'b1;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef AMNS_LOADER_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      case (state)
        IDLE: begin
          ready_q    <= 1'b1;
          core_rst_q <= 1'b1;
          busy_q     <= 1'b0;
          if (accept) begin
            if (s_tlast_i) begin
              // A one-beat frame can never be a complete operand set
              err_q <= 1'b1;
            end else begin
              err_q      <= 1'b0;
              cnt        <= AW'(1);
              state      <= LOAD;
              core_rst_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (accept) begin
            if (cnt == LAST_LOAD) begin
              cnt <= '0;
              if (s_tlast_i) begin
                state   <= START;
                ready_q <= 1'b0;
                start_q <= 1'b1;
              end else begin
                state <= FLUSH;
                err_q <= 1'b1;
              end
            end else if (s_tlast_i) begin
              state      <= IDLE;
              err_q      <= 1'b1;
              cnt        <= '0;
              core_rst_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end

        FLUSH: begin
          if (accept && s_tlast_i) begin
            state      <= IDLE;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end

        START: begin
          state <= WAIT_CORE;
`ifdef AMNS_LOADER_TIMEOUT_EN
          tcnt  <= '0;
`endif
        end

        WAIT_CORE: begin
          if (core_done_i) begin
            state   <= UNLOAD;
            rd_addr <= '0;
            out_cnt <= '0;
          end
`ifdef AMNS_LOADER_TIMEOUT_EN
          else if (tcnt == TO_LAST) begin
            state      <= IDLE;
            err_q      <= 1'b1;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
`endif
        end

        UNLOAD: begin
          if (issue) begin
            rd_addr <= rd_addr + AW'(1);
          end
          if (pop) begin
            if (out_cnt == RES_LAST) begin
              // Returning to IDLE re-asserts core reset, clearing its sticky done
              state      <= IDLE;
              core_rst_q <= 1'b1;
              busy_q     <= 1'b0;
              ready_q    <= 1'b1;
            end else begin
              out_cnt <= out_cnt + AW'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_amns_host_loader.sv
// ============================================================================
//  Module      : tb_amns_host_loader
//  Description : Directed self-checking bench for amns_host_loader with a
//                two-cycle-latency BRAM model and a hand-driven core done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_amns_host_loader;

  localparam int N  = 5;
  localparam int S  = 5;
  localparam int W  = 64;
  localparam int LW = 80;
  localparam int RW = 25;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tlast = 1'b0;
  logic         s_tready;
  logic [W-1:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready = 1'b1;
  logic         m_tlast;
  logic [6:0]   bram_addr;
  logic         bram_en;
  logic         bram_we;
  logic [W-1:0] bram_wdata;
  logic [W-1:0] rd1;
  logic [W-1:0] rd2;
  logic         core_rst;
  logic         core_start;
  logic         core_done = 1'b0;
  logic         busy;
  logic         error;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  amns_host_loader #(
    .S(S), .N(N), .WORD_W(W), .RD_LAT(2), .TIMEOUT_CYCLES(50)
  ) dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .s_tlast_i(s_tlast),
    .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready), .m_tlast_o(m_tlast),
    .bram_addr_o(bram_addr), .bram_en_o(bram_en), .bram_we_o(bram_we),
    .bram_wdata_o(bram_wdata), .bram_rdata_i(rd2),
    .core_rst_o(core_rst), .core_start_o(core_start), .core_done_i(core_done),
    .busy_o(busy), .error_o(error)
  );

  // BRAM model: write-first port, two-cycle read latency
  logic [W-1:0] mem [128];
  int wr_cnt = 0;
  int wr_hi  = 0;
  always @(posedge clk) begin
    if (bram_en && bram_we) begin
      mem[bram_addr] <= bram_wdata;
      wr_cnt <= wr_cnt + 1;
      if (bram_addr >= 7'(LW)) wr_hi <= wr_hi + 1;
    end
    if (bram_en && !bram_we) rd1 <= mem[bram_addr];
    rd2 <= rd1;
  end

  // Output-side monitor: start pulses, handshakes, stall stability
  int           cyc = 0;
  int           start_cnt = 0;
  int           rx_cnt = 0;
  int           stab_err = 0;
  logic [W-1:0] rx_data [256];
  logic         rx_last [256];
  int           rx_cyc [256];
  logic         stall_pend = 1'b0;
  logic [W-1:0] stall_dat = '0;
  always @(negedge clk) begin
    if (core_start) start_cnt++;
    if (m_tvalid && m_tready) begin
      rx_data[rx_cnt & 255] = m_tdata;
      rx_last[rx_cnt & 255] = m_tlast;
      rx_cyc[rx_cnt & 255]  = cyc;
      rx_cnt++;
    end
    if (stall_pend && (!m_tvalid || m_tdata !== stall_dat)) stab_err++;
    stall_pend = m_tvalid && !m_tready;
    stall_dat  = m_tdata;
    cyc++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One beat, held until accepted; returns 1 ns after the accepting edge
  task automatic send_beat(input logic [63:0] d, input logic last);
    int g;
    g = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = last;
    @(negedge clk);
    while (!s_tready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      n_cmp++;
      n_err++;
      $error("FAIL s_tready_wait: observed stalled %0d cycles required < 50", g);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_load(input int n, input int last_idx, input logic [31:0] base);
    for (int i = 0; i < n; i++) send_beat({base, 32'(i)}, i == last_idx);
  endtask

  task automatic chk_mem(input string tag, input logic [31:0] base);
    int bad;
    bad = 0;
    for (int i = 0; i < LW; i++) if (mem[i] !== {base, 32'(i)}) bad++;
    chk(tag, 64'(bad), 64'd0);
  endtask

  // Raise done, drain the result stream, check the 25 words against the load
  task automatic run_unload(input bit rnd, input logic [31:0] base);
    int g, r0, bad, lasts;
    r0 = rx_cnt;
    core_done = 1'b1;
    g = 0;
    while (busy && g < 1000) begin
      @(posedge clk);
      #1;
      if (rnd) m_tready = ($urandom_range(0, 2) != 0);
      g++;
    end
    if (g >= 1000) begin
      n_cmp++;
      n_err++;
      $error("FAIL unload_wait: observed busy after %0d cycles required idle", g);
    end
    core_done = 1'b0;
    m_tready  = 1'b1;
    chk("unload_count", 64'(rx_cnt - r0), 64'(RW));
    bad = 0;
    lasts = 0;
    for (int k = 0; k < RW; k++) begin
      if (rx_data[(r0 + k) & 255] !== {base, 32'(k)}) bad++;
      if (rx_last[(r0 + k) & 255]) lasts++;
    end
    chk("unload_data", 64'(bad), 64'd0);
    chk("unload_tlast_pos", 64'(rx_last[(r0 + RW - 1) & 255]), 64'd1);
    chk("unload_tlast_cnt", 64'(lasts), 64'd1);
    chk("unload_core_rst", 64'(core_rst), 64'd1);
    if (!rnd) chk("unload_throughput", 64'(rx_cyc[(r0 + RW - 1) & 255] - rx_cyc[r0 & 255]), 64'(RW - 1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish required finish before 400us");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, w0;
    // Reset state
    #12;
    chk("rst_core_rst", 64'(core_rst), 64'd1);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_start", 64'(core_start), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_bram_en", 64'(bram_en), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_s_tready", 64'(s_tready), 64'd1);

    // Nominal load, start pulse, 100-cycle core, full-rate unload
    s0 = start_cnt; w0 = wr_cnt;
    send_load(LW, LW - 1, 32'h1);
    chk("load1_start_on", 64'(core_start), 64'd1);
    chk("load1_s_tready", 64'(s_tready), 64'd0);
    chk("load1_core_rst", 64'(core_rst), 64'd0);
    chk("load1_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    chk("load1_start_off", 64'(core_start), 64'd0);
    chk_mem("load1_mem", 32'h1);
    chk("load1_wr_count", 64'(wr_cnt - w0), 64'(LW));
    repeat (98) begin @(posedge clk); #1; end
    chk("wait_no_valid", 64'(m_tvalid), 64'd0);
    chk("load1_start_count", 64'(start_cnt - s0), 64'd1);
    run_unload(1'b0, 32'h1);

    // Early tlast on beat 40
    s0 = start_cnt;
    send_load(41, 40, 32'h2);
    chk("early_error", 64'(error), 64'd1);
    chk("early_busy", 64'(busy), 64'd0);
    repeat (3) begin @(posedge clk); #1; end
    chk("early_no_start", 64'(start_cnt - s0), 64'd0);

    // Good load clears the error; unload under random backpressure
    send_load(LW, LW - 1, 32'h3);
    chk("reload_error_clr", 64'(error), 64'd0);
    chk("reload_start", 64'(core_start), 64'd1);
    chk_mem("reload_mem", 32'h3);
    repeat (10) begin @(posedge clk); #1; end
    run_unload(1'b1, 32'h3);

    // Missing tlast on beat 79, three extra beats flushed
    s0 = start_cnt; w0 = wr_cnt;
    send_load(LW + 3, LW + 2, 32'h4);
    chk("flush_error", 64'(error), 64'd1);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_wr_count", 64'(wr_cnt - w0), 64'(LW));
    chk("flush_wr_high", 64'(wr_hi), 64'd0);
    chk_mem("flush_mem", 32'h4);
    chk("flush_no_start", 64'(start_cnt - s0), 64'd0);

    // Asynchronous reset mid-load
    send_load(20, -1, 32'h5);
    s_tvalid = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_core_rst", 64'(core_rst), 64'd1);
    chk("arst_s_tready", 64'(s_tready), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_bram_en", 64'(bram_en), 64'd0);
    s_tvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Recovery after reset
    send_load(LW, LW - 1, 32'h6);
    chk("recover_start", 64'(core_start), 64'd1);
    chk_mem("recover_mem", 32'h6);
    repeat (5) begin @(posedge clk); #1; end
    run_unload(1'b0, 32'h6);

`ifdef AMNS_LOADER_TIMEOUT_EN
    // Core never finishes: watchdog fires after 50 WAIT_CORE cycles
    begin
      int g;
      send_load(LW, LW - 1, 32'h7);
      chk("to_start", 64'(core_start), 64'd1);
      g = 0;
      while (!error && g < 200) begin @(posedge clk); #1; g++; end
      chk("to_cycles", 64'(g), 64'd51);
      chk("to_busy", 64'(busy), 64'd0);
    end
`endif

    chk("stall_stability", 64'(stab_err), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
